fpu_instr_queue: RTL and testbench

- Parametrised instruction buffer and dispatcher placed between the CPU-side escape-opcode interface and the 8087 decoder/core pair.
- Accepts up to DEPTH instructions back-to-back, each with opcode, ModR/M, 80-bit operand and 32-bit integer operand.
- Issues them in order with a single-cycle execute pulse, one at a time, and halts on core error until software clears it.
- Replaces the single-instruction direct path, so the CPU no longer stalls per instruction.

---
 rtl/fpu_instr_queue.sv | 155 +++++++++++++++
 tb/tb_fpu_instr_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_instr_queue.sv
// In-order instruction queue between the CPU escape-opcode interface and the 8087 decoder/core.
// Optional watchdog on the core-completion wait is compiled in with FPU_QUEUE_TIMEOUT_EN.
module fpu_instr_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned GUARD_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_opcode,
  input  logic [7:0]                   in_modrm,
  input  logic [79:0]                  in_data,
  input  logic [31:0]                  in_int_data,
  output logic [7:0]                   core_opcode,
  output logic [7:0]                   core_modrm,
  output logic [79:0]                  core_data,
  output logic [31:0]                  core_int_data,
  output logic                         core_execute,
  input  logic                         core_ready,
  input  logic                         core_error,
  input  logic                         flush,
  input  logic                         err_clear,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         halted,
  output logic                         timeout_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned EW = 8 + 8 + 80 + 32;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GUARD_CYCLES < 1 || GUARD_CYCLES > 7 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fpu_instr_queue: invalid parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_HALT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_guard;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_go;
  logic            w_guard_done;
  logic            w_wd_fire;

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_push       = in_valid && in_ready;
  assign w_pop        = (r_state == S_ISSUE);
  assign w_go         = (r_state == S_IDLE) && (r_count != '0) && core_ready && !flush;
  assign w_guard_done = (r_guard == 3'(GUARD_CYCLES - 1));
  assign count        = r_count;

  // Pointers and occupancy; flush discards everything not yet issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_opcode, in_modrm, in_data, in_int_data};
  end

  // Head is latched on the IDLE->ISSUE edge and held until the next issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_opcode   <= '0;
      core_modrm    <= '0;
      core_data     <= '0;
      core_int_data <= '0;
    end else if (w_go) begin
      {core_opcode, core_modrm, core_data, core_int_data} <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_guard <= '0;
    else          r_guard <= (r_state == S_GUARD) ? r_guard + 3'd1 : '0;
  end

`ifdef FPU_QUEUE_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wd;
  logic          r_tmo;

  assign w_wd_fire   = (r_state == S_WAIT) && !core_ready && (r_wd == WW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_tmo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd  <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_wd <= (r_state == S_WAIT) ? r_wd + 1'b1 : '0;
      if (w_wd_fire)      r_tmo <= 1'b1;
      else if (err_clear) r_tmo <= 1'b0;
    end
  end
`else
  assign w_wd_fire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_next = S_ISSUE;
      S_ISSUE: w_next = S_GUARD;
      S_GUARD: if (w_guard_done) w_next = S_WAIT;
      S_WAIT: begin
        if (core_ready)     w_next = core_error ? S_HALT : S_IDLE;
        else if (w_wd_fire) w_next = S_HALT;
      end
      S_HALT:  if (err_clear) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    core_execute = (r_state == S_ISSUE);
    halted       = (r_state == S_HALT);
    busy         = (r_count != '0) || (r_state != S_IDLE);
    in_ready     = !w_full && (r_state != S_HALT) && !flush;
  end

endmodule

// File: tb/tb_fpu_instr_queue.sv
// Randomized bench for fpu_instr_queue against a queue-level reference model.
// Watchdog behaviour is checked when built with FPU_QUEUE_TIMEOUT_EN.
module tb_fpu_instr_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GUARD = 1;
  localparam int unsigned TMO   = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opcode;
  logic [7:0]  in_modrm;
  logic [79:0] in_data;
  logic [31:0] in_int_data;
  logic [7:0]  core_opcode;
  logic [7:0]  core_modrm;
  logic [79:0] core_data;
  logic [31:0] core_int_data;
  logic        core_execute;
  logic        core_ready;
  logic        core_error;
  logic        flush;
  logic        err_clear;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic        busy;
  logic        halted;
  logic        timeout_err;

  always #5 clk = ~clk;

  fpu_instr_queue #(
    .DEPTH(DEPTH),
    .GUARD_CYCLES(GUARD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_modrm(in_modrm), .in_data(in_data), .in_int_data(in_int_data),
    .core_opcode(core_opcode), .core_modrm(core_modrm), .core_data(core_data),
    .core_int_data(core_int_data), .core_execute(core_execute),
    .core_ready(core_ready), .core_error(core_error),
    .flush(flush), .err_clear(err_clear),
    .count(count), .busy(busy), .halted(halted), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending entries, the one issued instruction and its age in cycles
  // (age 0 is the execute cycle), halt and sticky timeout flags, last issued entry.
  logic [127:0] m_q[$];
  bit           m_inflight;
  bit           m_halt;
  bit           m_tmo;
  int           m_age;
  logic [127:0] m_last;

  task automatic model_reset();
    m_q.delete();
    m_inflight = 0;
    m_halt     = 0;
    m_tmo      = 0;
    m_age      = 0;
    m_last     = '0;
  endtask

  // Advance the model across the coming rising edge using the inputs now driven.
  task automatic model_step();
    bit push, exec_now, go, in_wait, done, tmo_fire;
    push     = in_valid && (m_q.size() < DEPTH) && !m_halt && !flush;
    exec_now = m_inflight && (m_age == 0);
    go       = !m_inflight && !m_halt && (m_q.size() > 0) && core_ready && !flush;
    in_wait  = m_inflight && (m_age >= GUARD + 1);
    done     = in_wait && core_ready;
    tmo_fire = 0;
`ifdef FPU_QUEUE_TIMEOUT_EN
    tmo_fire = in_wait && !core_ready && (m_age - GUARD == TMO);
`endif
    if (go) m_last = m_q[0];
    if (flush) m_q.delete();
    else begin
      if (exec_now) void'(m_q.pop_front());
      if (push) m_q.push_back({in_opcode, in_modrm, in_data, in_int_data});
    end
    m_halt = (m_halt && !err_clear) || (done && core_error) || tmo_fire;
    if (tmo_fire)       m_tmo = 1;
    else if (err_clear) m_tmo = 0;
    if (go) begin
      m_inflight = 1;
      m_age      = 0;
    end else if (done || tmo_fire) begin
      m_inflight = 0;
    end else if (m_inflight) begin
      m_age++;
    end
  endtask

  task automatic check_outputs();
    check("execute",     core_execute, m_inflight && (m_age == 0));
    check("count",       count, m_q.size());
    check("in_ready",    in_ready, (m_q.size() < DEPTH) && !m_halt && !flush);
    check("halted",      halted, m_halt);
    check("busy",        busy, (m_q.size() != 0) || m_inflight || m_halt);
    check("core_bus",    {core_opcode, core_modrm, core_data, core_int_data}, m_last);
    check("timeout_err", timeout_err, m_tmo);
  endtask

  task automatic rand_entry();
    logic [95:0] d;
    d           = {$urandom(), $urandom(), $urandom()};
    in_opcode   = 8'hD8 | 8'($urandom_range(0, 7));
    in_modrm    = 8'($urandom());
    in_data     = d[79:0];
    in_int_data = $urandom();
  endtask

  task automatic idle_inputs();
    in_valid   = 0;
    core_ready = 0;
    core_error = 0;
    flush      = 0;
    err_clear  = 0;
    rand_entry();
  endtask

  // pv..pc are per-cycle percentages for valid, ready, error, flush, err_clear.
  task automatic run_phase(input int cycles, input int pv, input int pr, input int pe,
                           input int pf, input int pc);
    repeat (cycles) begin
      @(negedge clk);
      check_outputs();
      rand_entry();
      in_valid   = ($urandom_range(0, 99) < pv);
      core_ready = ($urandom_range(0, 99) < pr);
      core_error = ($urandom_range(0, 99) < pe);
      flush      = ($urandom_range(0, 99) < pf);
      err_clear  = ($urandom_range(0, 99) < pc);
      model_step();
    end
  endtask

  task automatic check_reset_values();
    check("rst_execute", core_execute, 1'b0);
    check("rst_count",   count, 0);
    check("rst_busy",    busy, 1'b0);
    check("rst_halted",  halted, 1'b0);
    check("rst_tmo",     timeout_err, 1'b0);
    check("rst_bus",     {core_opcode, core_modrm, core_data, core_int_data}, 128'd0);
    check("rst_ready",   in_ready, 1'b1);
  endtask

  initial begin
    bit reached;
    idle_inputs();
    reset_n = 0;
    model_reset();
    #12;
    check_reset_values();
    @(negedge clk);
    reset_n = 1;
    model_step();

    run_phase(60, 70, 100, 0,  0, 0);   // steady streaming
    run_phase(30, 90, 0,   0,  0, 0);   // fill to full with core stalled
    run_phase(60, 30, 80,  0,  0, 0);   // drain, pointers wrap
    run_phase(80, 60, 70,  20, 0, 10);  // errors, halt and recovery
    run_phase(80, 60, 80,  10, 8, 15);  // flushes mixed in
    run_phase(50, 50, 0,   0,  0, 0);   // core never ready
    run_phase(60, 50, 100, 0,  0, 30);  // recover

    // Drive the queue into the completion wait, then reset asynchronously.
    reached = 0;
    for (int i = 0; i < 60 && !reached; i++) begin
      @(negedge clk);
      check_outputs();
      rand_entry();
      in_valid   = 1;
      core_ready = !m_inflight;
      core_error = 0;
      flush      = 0;
      err_clear  = m_halt;
      model_step();
      reached = m_inflight && (m_age >= GUARD + 1);
    end
    check("reach_wait", reached, 1'b1);
    @(posedge clk);
    #2;
    reset_n = 0;
    idle_inputs();
    #1;
    model_reset();
    check_reset_values();
    @(negedge clk);
    reset_n = 1;
    model_step();

    run_phase(60, 70, 90, 5, 3, 20);
    run_phase(40, 40, 0,  0, 0, 0);
    run_phase(40, 40, 100, 0, 0, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
